// File: rtl/add2_seq_pkg.sv
// add2_seq_pkg: shared types and constants for the digit-serial adder.
// State encoding, digit width and counter sizing helper.
package add2_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIGIT_W = 2;

    // Bits needed for a digit counter that loads width/2-1, minimum 1.
    function automatic int cnt_w(input int width);
        int n;
        n = width / DIGIT_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add2_seq_slice.sv
// add2_slice: combinational 2-bit full-adder slice.
// One digit plus carry-in produces a 2-bit sum and carry-out.
module add2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic [2:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {2'b00, cin};
    assign s     = total[1:0];
    assign cout  = total[2];

endmodule

// File: rtl/add2_seq.sv
// add2_seq: digit-serial WIDTH-bit adder, one 2-bit digit per clock.
// Optional subtract via ADD2_SEQ_SUB_EN (adds the in_sub port).
module add2_seq
    import add2_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef ADD2_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int CW   = cnt_w(WIDTH);
    localparam int NDIG = WIDTH / DIGIT_W;

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("add2_seq: WIDTH must be even and >= 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH+1:0] sum_ext;
    logic [1:0]       slice_s;
    logic             slice_cout;
    logic             sub;

`ifdef ADD2_SEQ_SUB_EN
    assign sub = in_sub;
`else
    assign sub = 1'b0;
`endif

    add2_slice u_slice (
        .a    (opa_q[1:0]),
        .b    (opb_q[1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Handshake flags come straight from the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

    // Next-state and datapath: load on accept, shift one digit per RUN cycle.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_ext = {slice_s, sum_q};
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = in_a;
                    opb_d   = sub ? ~in_b : in_b;
                    carry_d = sub;
                    sum_d   = '0;
                    cnt_d   = CW'(NDIG - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> DIGIT_W;
                opb_d   = opb_q >> DIGIT_W;
                sum_d   = sum_ext[WIDTH+1:DIGIT_W];
                carry_d = slice_cout;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_add2_seq.sv
// tb_add2_seq: directed checks for add2_seq at WIDTH=8 and WIDTH=2.
// Subtract vectors run only when ADD2_SEQ_SUB_EN is defined.
module tb_add2_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       iv8 = 1'b0, or8 = 1'b1, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, co8;
    logic [7:0] s8;

    logic       iv2 = 1'b0, or2 = 1'b1, sub2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       ir2, ov2, co2;
    logic [1:0] s2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add2_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_a      (a8),
        .in_b      (b8),
`ifdef ADD2_SEQ_SUB_EN
        .in_sub    (sub8),
`endif
        .out_valid (ov8),
        .out_ready (or8),
        .out_sum   (s8),
        .out_cout  (co8)
    );

    add2_seq #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .in_a      (a2),
        .in_b      (b2),
`ifdef ADD2_SEQ_SUB_EN
        .in_sub    (sub2),
`endif
        .out_valid (ov2),
        .out_ready (or2),
        .out_sum   (s2),
        .out_cout  (co2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one 8-bit op with out_ready high; check latency and result.
    task automatic op8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic sub,
                       input logic [7:0] es, input logic ec);
        int lat;
        chk({tag, "_ready"}, 32'(ir8), 32'd1);
        a8 = a; b8 = b; sub8 = sub; iv8 = 1'b1; or8 = 1'b1;
        tick();
        iv8 = 1'b0;
        chk({tag, "_busy"}, 32'(ir8), 32'd0);
        lat = 0;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(s8), 32'(es));
        chk({tag, "_cout"}, 32'(co8), 32'(ec));
        tick();
        chk({tag, "_rdy_after"}, 32'(ir8), 32'd1);
        chk({tag, "_ov_after"}, 32'(ov8), 32'd0);
    endtask

    initial begin
        int lat;
        int acc[$];
        logic [7:0] hs;
        logic hc;

        #12;
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_out_sum", 32'(s8), 32'd0);
        chk("rst_out_cout", 32'(co8), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
        op8("add_aa_55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
        op8("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef ADD2_SEQ_SUB_EN
        op8("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
        op8("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
`endif

        // Backpressure: hold result in DONE while pulsing in_valid.
        sub8 = 1'b0; or8 = 1'b0;
        a8 = 8'h12; b8 = 8'h34; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd4);
        hs = s8;
        hc = co8;
        chk("bp_sum", 32'(hs), 32'h46);
        chk("bp_cout", 32'(hc), 32'd0);
        for (int i = 0; i < 5; i++) begin
            a8 = 8'hF0; b8 = 8'h0F; iv8 = i[0];
            tick();
            chk("bp_hold_valid", 32'(ov8), 32'd1);
            chk("bp_hold_ready", 32'(ir8), 32'd0);
            chk("bp_hold_sum", 32'(s8), 32'h46);
            chk("bp_hold_cout", 32'(co8), 32'd0);
        end
        iv8 = 1'b0; or8 = 1'b1;
        tick();
        chk("bp_release_ready", 32'(ir8), 32'd1);
        chk("bp_release_valid", 32'(ov8), 32'd0);
        tick();
        tick();
        chk("bp_no_extra", 32'(ov8), 32'd0);

        // Reset during the second RUN cycle aborts the operation.
        a8 = 8'h5A; b8 = 8'h3C; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        chk("abort_pre_sum", 32'(s8), 32'h80);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(ov8), 32'd0);
        chk("abort_ready", 32'(ir8), 32'd1);
        chk("abort_sum", 32'(s8), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        op8("after_abort", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

        // WIDTH=2: single-digit latency.
        a2 = 2'd3; b2 = 2'd3; iv2 = 1'b1; or2 = 1'b0;
        chk("w2_ready", 32'(ir2), 32'd1);
        tick();
        iv2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 20) begin
            tick();
            lat++;
        end
        chk("w2_lat", 32'(lat), 32'd1);
        chk("w2_sum", 32'(s2), 32'd2);
        chk("w2_cout", 32'(co2), 32'd1);
        or2 = 1'b1;
        tick();
        chk("w2_ready_after", 32'(ir2), 32'd1);

        // WIDTH=2 back-to-back with in_valid held: interval 3.
        a2 = 2'd1; b2 = 2'd2; iv2 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ir2) acc.push_back(c);
            if (ov2) begin
                chk("w2_b2b_sum", 32'(s2), 32'd3);
                chk("w2_b2b_cout", 32'(co2), 32'd0);
            end
            tick();
        end
        iv2 = 1'b0;
        chk("w2_b2b_count", 32'(acc.size()), 32'd4);
        if (acc.size() >= 2) begin
            chk("w2_interval", 32'(acc[1] - acc[0]), 32'd3);
        end else begin
            chk("w2_interval", 32'd0, 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/add2_seq.md
# add2_seq

Digit-serial W-bit adder sequencer. It accepts two W-bit operands over a valid/ready handshake and steps a single 2-bit full-adder slice across the operands, least-significant digit first, one digit per clock, using a registered carry. It returns the W-bit sum plus carry-out over a second valid/ready handshake. It sits between an operand producer and a result consumer wherever a wide add is needed but only one 2-bit adder slice is affordable.

## Interface
- WIDTH, 8, operand/sum width in bits; must be even and ≥2 (elaboration error otherwise)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair available
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  subtract request, A−B (present only with ADD2_SEQ_SUB_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_sum  out  WIDTH  sum (or difference), modulo 2^WIDTH
- out_cout  out  1  carry-out of MSB digit (for subtract: 1 = no borrow)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: latch in_a→opa, in_b→opb (inverted when subtracting), carry←0 (1 when subtracting), digit counter←WIDTH/2−1, go RUN.
- RUN: each cycle the slice adds opa[1:0]+opb[1:0]+carry; carry←slice cout; 2-bit result shifted into sum register from the top; opa/opb shift right by 2; counter decrements. When the counter is 0 in this cycle, go DONE.
- DONE: out_valid=1; out_sum=sum register, out_cout=carry, both stable. On out_ready, go IDLE. in_ready=0 in DONE and RUN (no overlap of operations).
- in_valid ignored outside IDLE; out_ready ignored outside DONE.
- Arithmetic: wrap-around modulo 2^WIDTH; carry-out reported, never saturated.
- Reset at any time, including mid-RUN or in DONE with out_ready low: abort immediately, state IDLE, all registers cleared, no result emitted.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_sum=0, out_cout=0.
- in_ready and out_valid are decoded from the state register only, never combinationally from in_valid or out_ready.
- Latency: out_valid rises exactly WIDTH/2 cycles after the accept edge. WIDTH=8 gives 4 cycles; WIDTH=2 gives 1 cycle.
- in_ready returns high the cycle after the out handshake edge.
- Minimum issue interval: WIDTH/2+2 cycles.

## Configuration
- ADD2_SEQ_SUB_EN defined: in_sub port exists and is latched at accept. When in_sub=1, operand B is inverted and the initial carry is 1, giving A−B mod 2^WIDTH with out_cout=1 meaning no borrow.
- ADD2_SEQ_SUB_EN not defined: no in_sub port, and the block is add-only with initial carry 0. Cycle timing is identical in both builds.

## Structure
- add2_seq_pkg: state enum (IDLE/RUN/DONE), DIGIT_W=2 constant, and a counter-width function clog2(WIDTH/2) floored to 1.
- Sub-module add2_slice: purely combinational 2-bit adder with a, b, cin inputs and s[1:0], cout outputs. Instantiated once. add2_seq holds all sequential logic.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, out_ready=1 → out_valid exactly 4 cycles after accept, out_sum=0x96, out_cout=0, in_ready high the next cycle.
- WIDTH=8, A=0xFF, B=0x01 → out_sum=0x00, out_cout=1 (wrap-around, carry propagates through all 4 digits).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid → out_sum/out_cout held stable, in_ready=0, extra operands not accepted.
- Reset asserted during the 2nd RUN cycle → same cycle: out_valid=0, in_ready=1, out_sum=0; next operand pair completes correctly.
- With ADD2_SEQ_SUB_EN, WIDTH=8: 0x10−0x01 → 0x0F, cout=1; 0x01−0x02 → 0xFF, cout=0.
- WIDTH=2: A=3, B=3 → out_valid 1 cycle after accept, out_sum=2, out_cout=1. Back-to-back ops with in_valid held high → issue interval 3 cycles.
